// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and coordinate type for the 640x480@60 raster generator.
package vga_timing_pkg;
  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;
  localparam int unsigned V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to pixel producers and the connector.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-MOD counter with enable; reset parks on MOD-1 so the first enable wraps to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MOD = 800
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output coord_t count_nxt,
  output logic   wrap
);
  localparam coord_t LAST = coord_t'(MOD - 1);

  assign wrap      = en && (count == LAST);
  assign count_nxt = !en ? count : (wrap ? '0 : count + 1'b1);

  always_ff @(posedge clk) begin
    if (reset) count <= LAST;
    else       count <= count_nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel-tick divider, h/v counters, registered sync/blank decode, frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D,
  parameter int unsigned PIX_DIV  = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || (PIX_DIV != 1 && PIX_DIV != 2)) begin : g_bad_params
    $error("vga_timing_gen: totals must be <= 1024 and PIX_DIV must be 1 or 2");
  end

  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t HS_BEG   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t VS_BEG   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic   DIV_LAST = 1'(PIX_DIV - 1);

  logic   div, tick, h_wrap, v_wrap;
  coord_t hc, vc, hc_nxt, vc_nxt;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) div <= 1'b0;
    else       div <= tick ? 1'b0 : div + 1'b1;
  end

  vga_axis_counter #(.MOD(H_TOTAL)) u_hcnt (
    .clk(vga_clk), .reset(reset), .en(tick),
    .count(hc), .count_nxt(hc_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(.MOD(V_TOTAL)) u_vcnt (
    .clk(vga_clk), .reset(reset), .en(tick && h_wrap),
    .count(vc), .count_nxt(vc_nxt), .wrap(v_wrap)
  );

  assign vga.DrawX = hc;
  assign vga.DrawY = vc;

  // Decode from the next position so the flags land in the same edge as the counters.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga.blank       <= 1'b0;
      vga.hs          <= 1'b1;
      vga.vs          <= 1'b1;
      vga.frame_start <= 1'b0;
      vga.frame_count <= '0;
    end else begin
      vga.blank       <= (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
      vga.hs          <= !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      vga.vs          <= !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      vga.frame_start <= v_wrap;
      if (tick && h_wrap && (vc_nxt == VS_BEG))
        vga.frame_count <= vga.frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generators (default timing, tiny timing at PIX_DIV 1 and 2) checked every cycle against a closed-form raster model.
module tb_vga_timing_gen;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 2, SVS = 1, SVB = 2;
  localparam int SFT = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  int         e0, e1, e2, cyc;
  int         n_chk = 0, n_err = 0;
  bit         armed = 0, phase_c = 0, fc_wrap_seen = 0;
  int         last_fs = -1;
  logic [7:0] prev_fc1 = '0;

  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();

  vga_timing_gen u_dut0 (.vga_clk(clk), .reset(rst[0]), .vga(if0));
  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIX_DIV(1)
  ) u_dut1 (.vga_clk(clk), .reset(rst[1]), .vga(if1));
  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIX_DIV(2)
  ) u_dut2 (.vga_clk(clk), .reset(rst[2]), .vga(if2));

  // Edges since the last reset edge; the whole raster state is a function of this count.
  always @(posedge clk) begin
    e0  <= rst[0] ? 0 : e0 + 1;
    e1  <= rst[1] ? 0 : e1 + 1;
    e2  <= rst[2] ? 0 : e2 + 1;
    cyc <= cyc + 1;
  end
  initial cyc = 0;

  function automatic logic [32:0] model(int e, int pd, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb);
    int ht, vt, ft, ticks, l, hc, vc, tgt, fc;
    logic bl, h, v, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ft = ht * vt;
    ticks = e / pd;
    l  = (ft - 1 + ticks) % ft;
    hc = l % ht;
    vc = l / ht;
    bl = (hc < ha) && (vc < va);
    h  = !((hc >= ha + hf) && (hc < ha + hf + hs));
    v  = !((vc >= va + vf) && (vc < va + vf + vs));
    fs = (e > 0) && (e % pd == 0) && (l == 0);
    tgt = (va + vf) * ht;
    fc = (ticks >= tgt + 1) ? ((ticks - tgt - 1) / ft + 1) % 256 : 0;
    return {10'(hc), 10'(vc), bl, h, v, fs, 8'(fc)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk($sformatf("dflt e=%0d", e0),
          {if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs, if0.frame_start, if0.frame_count},
          model(e0, 1, 640, 16, 96, 48, 480, 10, 2, 33));
      chk($sformatf("div1 e=%0d", e1),
          {if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs, if1.frame_start, if1.frame_count},
          model(e1, 1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
      chk($sformatf("div2 e=%0d", e2),
          {if2.DrawX, if2.DrawY, if2.blank, if2.hs, if2.vs, if2.frame_start, if2.frame_count},
          model(e2, 2, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
    end
    if (phase_c) begin
      if (prev_fc1 == 8'd255 && if1.frame_count == 8'd0) fc_wrap_seen = 1;
      prev_fc1 = if1.frame_count;
      if (if2.frame_start) begin
        if (last_fs >= 0) chk("fs_gap_div2", 64'(cyc - last_fs), 64'(2 * SFT));
        last_fs = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    armed = 1;
    rst = 3'b000;
    // Random mid-frame reset pulses on each generator independently.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #1;
    rst = 3'b000;
    phase_c = 1;
    repeat (256 * SFT + 300) @(posedge clk);
    #1;
    chk("fc_wrap_255_to_0", 64'(fc_wrap_seen), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
